// File: rtl/ex_stage_pkg.sv
// ex_pkg: shared constants and types for the execute stage.
//   XLEN / RIDX   datapath and register-index widths
//   state_t       control FSM states
//   *_xxx         func_i sub-operation encodings per instruction class
//   ex_out_t      bundle of everything the stage registers toward mem/wb
package ex_pkg;

  localparam int XLEN = 32;
  localparam int RIDX = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // inte class, func[0]; zero selects add
  localparam logic INT_SUB = 1'b1;

  // logic class, func[1:0]
  localparam logic [1:0] LOG_AND  = 2'b00;
  localparam logic [1:0] LOG_OR   = 2'b01;
  localparam logic [1:0] LOG_XOR  = 2'b10;
  localparam logic [1:0] LOG_NOTB = 2'b11;

  // shift class, func[1:0]
  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_ROTL = 2'b11;

  // branch conditions, func[1:0]
  localparam logic [1:0] BR_ALWAYS = 2'b00;
  localparam logic [1:0] BR_EQZ    = 2'b01;
  localparam logic [1:0] BR_NEZ    = 2'b10;
  localparam logic [1:0] BR_NEG    = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [RIDX-1:0] wb_r;
    logic            wb;
    logic            mem_re;
    logic            mem_we;
    logic [XLEN-1:0] mem_wdata;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
  } ex_out_t;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID -> EX operand/class bundle, hold handshake, and EX -> mem/wb
// results.
//   slave  : the execute stage (consumes operands, drives results/stall_o)
//   master : the surrounding pipeline (drives operands, observes results)
interface ex_stage_if #(
  parameter int XLEN = ex_pkg::XLEN,
  parameter int RIDX = ex_pkg::RIDX
);

  logic [XLEN-1:0] rd_value_i;
  logic [XLEN-1:0] rs_value_i;
  logic [XLEN-1:0] imm_value_i;
  logic            immf_i;
  logic [2:0]      func_i;
  logic [RIDX-1:0] rd_i;
  logic            ctrl_inte_i;
  logic            ctrl_logic_i;
  logic            ctrl_shift_i;
  logic            ctrl_ld_i;
  logic            ctrl_st_i;
  logic            ctrl_br_i;
  logic            stall_i;
  logic            stall_o;
  logic [XLEN-1:0] result_o;
  logic [RIDX-1:0] wb_r_o;
  logic            wb_o;
  logic            mem_re_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            br_taken_o;
  logic [XLEN-1:0] br_target_o;

  modport slave (
    input  rd_value_i, rs_value_i, imm_value_i, immf_i, func_i, rd_i,
           ctrl_inte_i, ctrl_logic_i, ctrl_shift_i, ctrl_ld_i, ctrl_st_i,
           ctrl_br_i, stall_i,
    output stall_o, result_o, wb_r_o, wb_o, mem_re_o, mem_we_o, mem_wdata_o,
           br_taken_o, br_target_o
  );

  modport master (
    output rd_value_i, rs_value_i, imm_value_i, immf_i, func_i, rd_i,
           ctrl_inte_i, ctrl_logic_i, ctrl_shift_i, ctrl_ld_i, ctrl_st_i,
           ctrl_br_i, stall_i,
    input  stall_o, result_o, wb_r_o, wb_o, mem_re_o, mem_we_o, mem_wdata_o,
           br_taken_o, br_target_o
  );

endinterface

// File: rtl/ex_stage_shifter.sv
// ex_shifter: iterative one-bit-per-step shifter (SLL/SRL/SRA/ROTL).
//   clk, rst     clock, async active-low reset
//   en           advance enable (low freezes accumulator and count)
//   start        load accumulator = a, count = amt, latch op
//   op, a, amt   operation, operand, shift amount
//   busy         count is non-zero
//   done         the next enabled edge performs the final step
//   result       accumulator after one more step (final value when done)
module ex_shifter
  import ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [4:0]      amt,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] acc_q;
  logic [4:0]      cnt_q;
  logic [1:0]      op_q;

  always_comb begin
    result = acc_q;
    unique case (op_q)
      SH_SLL:  result = {acc_q[XLEN-2:0], 1'b0};
      SH_SRL:  result = {1'b0, acc_q[XLEN-1:1]};
      SH_SRA:  result = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      SH_ROTL: result = {acc_q[XLEN-2:0], acc_q[XLEN-1]};
      default: result = acc_q;
    endcase
  end

  assign busy = (cnt_q != 5'd0);
  assign done = (cnt_q == 5'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      op_q  <= '0;
    end else if (en) begin
      if (start) begin
        acc_q <= a;
        cnt_q <= amt;
        op_q  <= op;
      end else if (busy) begin
        acc_q <= result;
        cnt_q <= cnt_q - 5'd1;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. Single-cycle ALU / ld-st address / branch, with
// iterative shifts that hold ID through stall_o.
//   clk, rst   clock, async active-low reset
//   bus        ex_stage_if.slave: operands and class flags from ID, stall
//              handshake, registered results toward mem/wb
//
// state   | meaning
// S_IDLE  | capture inputs on every non-stalled edge, register results
// S_SHIFT | shifter stepping; ID held, result registered on final step
module ex_stage
  import ex_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);

  state_t          state_q, state_nx;
  ex_out_t         out_q, out_nx, alu_out;
  logic            out_load;
  logic            sh_start, sh_busy, sh_done;
  logic [XLEN-1:0] op_b, sh_result;
  logic [RIDX-1:0] rd_q;
  logic            shift_iter;
  logic            unused_func_msb;

  assign unused_func_msb = bus.func_i[2];

  assign op_b       = bus.immf_i ? bus.imm_value_i : bus.rs_value_i;
  // A shift by zero completes like any single-cycle op.
  assign shift_iter = bus.ctrl_shift_i && (op_b[4:0] != 5'd0);

  always_comb begin
    alu_out = '0;
    if (bus.ctrl_inte_i) begin
      alu_out.result = (bus.func_i[0] == INT_SUB) ? bus.rd_value_i - op_b
                                                  : bus.rd_value_i + op_b;
      alu_out.wb     = 1'b1;
      alu_out.wb_r   = bus.rd_i;
    end else if (bus.ctrl_logic_i) begin
      unique case (bus.func_i[1:0])
        LOG_AND:  alu_out.result = bus.rd_value_i & op_b;
        LOG_OR:   alu_out.result = bus.rd_value_i | op_b;
        LOG_XOR:  alu_out.result = bus.rd_value_i ^ op_b;
        LOG_NOTB: alu_out.result = ~op_b;
        default:  alu_out.result = '0;
      endcase
      alu_out.wb   = 1'b1;
      alu_out.wb_r = bus.rd_i;
    end else if (bus.ctrl_shift_i) begin
      alu_out.result = bus.rd_value_i;
      alu_out.wb     = 1'b1;
      alu_out.wb_r   = bus.rd_i;
    end else if (bus.ctrl_ld_i) begin
      alu_out.result = bus.rs_value_i + bus.imm_value_i;
      alu_out.mem_re = 1'b1;
      alu_out.wb     = 1'b1;
      alu_out.wb_r   = bus.rd_i;
    end else if (bus.ctrl_st_i) begin
      alu_out.result    = bus.rs_value_i + bus.imm_value_i;
      alu_out.mem_we    = 1'b1;
      alu_out.mem_wdata = bus.rd_value_i;
    end else if (bus.ctrl_br_i) begin
      alu_out.br_target = op_b;
      unique case (bus.func_i[1:0])
        BR_ALWAYS: alu_out.br_taken = 1'b1;
        BR_EQZ:    alu_out.br_taken = (bus.rd_value_i == '0);
        BR_NEZ:    alu_out.br_taken = (bus.rd_value_i != '0);
        BR_NEG:    alu_out.br_taken = bus.rd_value_i[XLEN-1];
        default:   alu_out.br_taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nx = state_q;
    sh_start = 1'b0;
    out_load = 1'b0;
    out_nx   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.stall_i) begin
          out_load = 1'b1;
          if (shift_iter) begin
            sh_start = 1'b1;
            state_nx = S_SHIFT;
          end else begin
            out_nx = alu_out;
          end
        end
      end
      S_SHIFT: begin
        if (!bus.stall_i) begin
          if (sh_done) begin
            out_load      = 1'b1;
            out_nx.result = sh_result;
            out_nx.wb     = 1'b1;
            out_nx.wb_r   = rd_q;
            state_nx      = S_IDLE;
          end else if (!sh_busy) begin
            // Shifter idle without a completion: never strand ID.
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_nx;
      if (out_load) out_q <= out_nx;
      if (sh_start) rd_q <= bus.rd_i;
    end
  end

  ex_shifter u_shifter (
    .clk    (clk),
    .rst    (rst),
    .en     (!bus.stall_i),
    .start  (sh_start),
    .op     (bus.func_i[1:0]),
    .a      (bus.rd_value_i),
    .amt    (op_b[4:0]),
    .busy   (sh_busy),
    .done   (sh_done),
    .result (sh_result)
  );

  assign bus.stall_o     = (state_q == S_SHIFT) | bus.stall_i;
  assign bus.result_o    = out_q.result;
  assign bus.wb_r_o      = out_q.wb_r;
  assign bus.wb_o        = out_q.wb;
  assign bus.mem_re_o    = out_q.mem_re;
  assign bus.mem_we_o    = out_q.mem_we;
  assign bus.mem_wdata_o = out_q.mem_wdata;
  assign bus.br_taken_o  = out_q.br_taken;
  assign bus.br_target_o = out_q.br_target;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed steps followed by randomized instructions,
// each compared against a behavioural model of the instruction set.
module tb_ex_stage;

  localparam int C_BUB = 0;
  localparam int C_INT = 1;
  localparam int C_LOG = 2;
  localparam int C_SHF = 3;
  localparam int C_LD  = 4;
  localparam int C_ST  = 5;
  localparam int C_BR  = 6;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  wb_r;
    logic        wb;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic        bt;
    logic [31:0] tgt;
    logic        chk_res;
    logic        chk_wd;
    logic        chk_tgt;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int cls, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] rs,
                                 input logic [31:0] imm, input logic immf,
                                 input logic [3:0] rd);
    exp_t        e;
    logic [31:0] b;
    int          n;
    e = '{default: '0};
    b = immf ? imm : rs;
    n = int'(b[4:0]);
    case (cls)
      C_INT: begin
        e.result = f[0] ? a - b : a + b;
        e.wb = 1'b1; e.chk_res = 1'b1;
      end
      C_LOG: begin
        case (f[1:0])
          2'd0: e.result = a & b;
          2'd1: e.result = a | b;
          2'd2: e.result = a ^ b;
          default: e.result = ~b;
        endcase
        e.wb = 1'b1; e.chk_res = 1'b1;
      end
      C_SHF: begin
        case (f[1:0])
          2'd0: e.result = a << n;
          2'd1: e.result = a >> n;
          2'd2: e.result = $signed(a) >>> n;
          default: e.result = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
        endcase
        e.wb = 1'b1; e.chk_res = 1'b1; e.lat = n;
      end
      C_LD: begin
        e.result = rs + imm;
        e.re = 1'b1; e.wb = 1'b1; e.chk_res = 1'b1;
      end
      C_ST: begin
        e.result = rs + imm; e.wdata = a;
        e.we = 1'b1; e.chk_res = 1'b1; e.chk_wd = 1'b1;
      end
      C_BR: begin
        case (f[1:0])
          2'd0: e.bt = 1'b1;
          2'd1: e.bt = (a == 32'd0);
          2'd2: e.bt = (a != 32'd0);
          default: e.bt = a[31];
        endcase
        e.tgt = b; e.chk_tgt = 1'b1;
      end
      default: ;
    endcase
    if (e.wb) e.wb_r = rd;
    return e;
  endfunction

  task automatic set_in(input int cls, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] rs, input logic [31:0] imm,
                        input logic immf, input logic [3:0] rd);
    bus.ctrl_inte_i  = (cls == C_INT);
    bus.ctrl_logic_i = (cls == C_LOG);
    bus.ctrl_shift_i = (cls == C_SHF);
    bus.ctrl_ld_i    = (cls == C_LD);
    bus.ctrl_st_i    = (cls == C_ST);
    bus.ctrl_br_i    = (cls == C_BR);
    bus.func_i       = f;
    bus.rd_value_i   = a;
    bus.rs_value_i   = rs;
    bus.imm_value_i  = imm;
    bus.immf_i       = immf;
    bus.rd_i         = rd;
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".wb_o"}, {31'd0, bus.wb_o}, {31'd0, e.wb});
    chk({tag, ".mem_re_o"}, {31'd0, bus.mem_re_o}, {31'd0, e.re});
    chk({tag, ".mem_we_o"}, {31'd0, bus.mem_we_o}, {31'd0, e.we});
    chk({tag, ".br_taken_o"}, {31'd0, bus.br_taken_o}, {31'd0, e.bt});
    chk({tag, ".stall_o"}, {31'd0, bus.stall_o}, 32'd0);
    if (e.wb) chk({tag, ".wb_r_o"}, {28'd0, bus.wb_r_o}, {28'd0, e.wb_r});
    if (e.chk_res) chk({tag, ".result_o"}, bus.result_o, e.result);
    if (e.chk_wd) chk({tag, ".mem_wdata_o"}, bus.mem_wdata_o, e.wdata);
    if (e.chk_tgt) chk({tag, ".br_target_o"}, bus.br_target_o, e.tgt);
  endtask

  task automatic run_op(input string tag, input int cls, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] rs,
                        input logic [31:0] imm, input logic immf,
                        input logic [3:0] rd);
    exp_t e;
    e = model(cls, f, a, rs, imm, immf, rd);
    set_in(cls, f, a, rs, imm, immf, rd);
    @(posedge clk); #1;
    if (e.lat > 0) begin
      chk({tag, ".start_wb_o"}, {31'd0, bus.wb_o}, 32'd0);
      for (int k = 0; k < e.lat; k++) begin
        chk({tag, ".busy_stall_o"}, {31'd0, bus.stall_o}, 32'd1);
        @(posedge clk); #1;
      end
    end
    check_out(tag, e);
  endtask

  initial begin
    exp_t e;
    int   hi_cnt;
    int   cls;

    bus.stall_i = 1'b0;
    set_in(C_BUB, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst.result_o", bus.result_o, 32'd0);
    chk("rst.wb_r_o", {28'd0, bus.wb_r_o}, 32'd0);
    chk("rst.wb_o", {31'd0, bus.wb_o}, 32'd0);
    chk("rst.mem_re_o", {31'd0, bus.mem_re_o}, 32'd0);
    chk("rst.mem_we_o", {31'd0, bus.mem_we_o}, 32'd0);
    chk("rst.mem_wdata_o", bus.mem_wdata_o, 32'd0);
    chk("rst.br_taken_o", {31'd0, bus.br_taken_o}, 32'd0);
    chk("rst.br_target_o", bus.br_target_o, 32'd0);
    chk("rst.stall_o", {31'd0, bus.stall_o}, 32'd0);
    rst = 1'b1;

    // ALU
    run_op("add", C_INT, 3'b000, 32'd5, 32'd7, 32'd0, 1'b0, 4'd3);
    run_op("sub", C_INT, 3'b001, 32'd1, 32'd0, 32'd2, 1'b1, 4'd4);
    run_op("xor", C_LOG, 3'b010, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'd0, 1'b0, 4'd5);
    run_op("notb", C_LOG, 3'b011, 32'h1234_5678, 32'd0, 32'h0000_FFFF, 1'b1, 4'd6);

    // shifts
    run_op("sll5", C_SHF, 3'b000, 32'd1, 32'd0, 32'd5, 1'b1, 4'd2);
    run_op("sra4", C_SHF, 3'b010, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 4'd8);
    run_op("shift0", C_SHF, 3'b001, 32'h0000_1234, 32'd32, 32'd0, 1'b0, 4'd1);
    run_op("rotl1", C_SHF, 3'b011, 32'h8000_0001, 32'd1, 32'd0, 1'b0, 4'd12);

    // stall_i held two cycles in the middle of a 3-step shift
    e = model(C_SHF, 3'b001, 32'h0000_00F0, 32'd0, 32'd3, 1'b1, 4'd9);
    set_in(C_SHF, 3'b001, 32'h0000_00F0, 32'd0, 32'd3, 1'b1, 4'd9);
    @(posedge clk); #1;
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.stall_i = (i == 1 || i == 2);
      #1;
      if (!bus.stall_o) break;
      hi_cnt++;
      @(posedge clk); #1;
    end
    bus.stall_i = 1'b0;
    chk("stall.width", hi_cnt, 32'd5);
    check_out("stall", e);

    // reset in the middle of a shift
    set_in(C_SHF, 3'b000, 32'd3, 32'd0, 32'd10, 1'b1, 4'd5);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst.stall_o", {31'd0, bus.stall_o}, 32'd0);
    chk("midrst.wb_o", {31'd0, bus.wb_o}, 32'd0);
    chk("midrst.result_o", bus.result_o, 32'd0);
    set_in(C_BUB, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_op("post_rst_add", C_INT, 3'b000, 32'd100, 32'd23, 32'd0, 1'b0, 4'd7);

    // branches
    run_op("br_eqz_t", C_BR, 3'b001, 32'd0, 32'd0, 32'h100, 1'b1, 4'd0);
    run_op("br_pulse", C_BUB, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
    run_op("br_eqz_nt", C_BR, 3'b001, 32'd1, 32'd0, 32'h100, 1'b1, 4'd0);
    run_op("br_neg", C_BR, 3'b011, 32'h8000_0000, 32'h44, 32'd0, 1'b0, 4'd0);

    // memory
    run_op("st", C_ST, 3'd0, 32'hAB, 32'h10, 32'd4, 1'b1, 4'd3);
    run_op("ld", C_LD, 3'd0, 32'd0, 32'h100, 32'h20, 1'b1, 4'd7);

    // stall_i freezes the load strobe; it drops once the bubble is captured
    set_in(C_BUB, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
    bus.stall_i = 1'b1;
    @(posedge clk); #1;
    chk("freeze.mem_re_o", {31'd0, bus.mem_re_o}, 32'd1);
    chk("freeze.result_o", bus.result_o, 32'h120);
    chk("freeze.stall_o", {31'd0, bus.stall_o}, 32'd1);
    bus.stall_i = 1'b0;
    @(posedge clk); #1;
    chk("unfreeze.mem_re_o", {31'd0, bus.mem_re_o}, 32'd0);

    // randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      cls = int'($urandom_range(0, 6));
      run_op("rand", cls, 3'($urandom), $urandom, $urandom, $urandom,
             1'($urandom), 4'($urandom));
    end

    set_in(C_BUB, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage core, placed between `ID` and the memory/writeback stages. It consumes the operand values and class flags that `ID` produces, and performs the integer, logic, load/store address and branch operations in one cycle. Shifts run iteratively at one bit per cycle, and `ID` is held through `stall_o` while a shift is in progress. The result and register index are registered and forwarded to memory/writeback; writeback eventually returns them to `ID` as `wb_r_i`, `wb_i` and `wb_data_i`.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `RIDX`, 4: register index width (16 registers).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rd_value_i` in XLEN: operand A (destination register value).
- `rs_value_i` in XLEN: source register value.
- `imm_value_i` in XLEN: sign-extended immediate.
- `immf_i` in 1: when 1, operand B = immediate; when 0, operand B = rs.
- `func_i` in 3: opcode bits [27:25], which select the sub-operation.
- `rd_i` in RIDX: destination register index.
- `ctrl_inte_i`, `ctrl_logic_i`, `ctrl_shift_i`, `ctrl_ld_i`, `ctrl_st_i`, `ctrl_br_i` in 1 each: one-hot instruction class; all zero means bubble.
- `stall_i` in 1: downstream hold.
- `stall_o` out 1: hold request to `ID`.
- `result_o` out XLEN: ALU/shift result, or memory address for ld/st.
- `wb_r_o` out RIDX: destination index.
- `wb_o` out 1: result is to be written back.
- `mem_re_o`, `mem_we_o` out 1: load / store request.
- `mem_wdata_o` out XLEN: store data (operand A).
- `br_taken_o` out 1: branch taken (one-cycle pulse per branch).
- `br_target_o` out XLEN: branch target.

## Operation
Operand selection: A = `rd_value_i`; B = `immf_i ? imm_value_i : rs_value_i`.

Class behaviour:
- inte, `func[0]`: 0 = A+B, 1 = A−B; modulo 2^XLEN, no flags; `wb_o`=1.
- logic, `func[1:0]`: 00 AND, 01 OR, 10 XOR, 11 ~B; `wb_o`=1.
- shift, `func[1:0]`: 00 SLL, 01 SRL, 10 SRA, 11 ROTL of A by B[4:0]; B[31:5] ignored; `wb_o`=1.
- ld: `result_o` = `rs_value_i` + `imm_value_i`; `mem_re_o`=1; `wb_o`=1 (writeback substitutes the memory data).
- st: `result_o` = `rs_value_i` + `imm_value_i`; `mem_we_o`=1; `mem_wdata_o`=A; `wb_o`=0.
- br: condition on `func[1:0]`: 00 always, 01 A==0, 10 A!=0, 11 A[31]. `br_target_o` = B; `wb_o`=0.
- Bubble: `wb_o`, `mem_re_o`, `mem_we_o` and `br_taken_o` are all 0.

State machine:
- IDLE: captures the inputs at each edge where `stall_i`=0.
  - Non-shift, or shift with amount 0: outputs registered at that edge; remain in IDLE.
  - Shift with amount n>0: load accumulator = A and count = n; go to SHIFT. Output control bits at that edge are 0 (bubble).
- SHIFT: each edge with `stall_i`=0 shifts the accumulator one bit and decrements count. At the edge where count==1, register the result with `wb_o`=1 and `wb_r_o`=captured `rd_i`, then return to IDLE.
- `stall_o` = (state==SHIFT) | `stall_i`, combinational.

Freeze and reset:
- `stall_i`=1 freezes all state and outputs, including a shift in progress; inputs are not captured.
- `rst` low at any time, including mid-shift, aborts the current operation: state = IDLE and every output = 0. The first capture happens at the first rising edge after `rst` deasserts.

## Timing
- ALU, ld/st and br latency: 1 edge from capture to outputs.
- Shift by n≥1: outputs valid n edges after capture. `stall_o` is high for exactly n cycles, assuming `stall_i`=0. Inputs presented by `ID` during this window are ignored; `ID` holds them.
- `br_taken_o` and the memory strobes are high for exactly one cycle per instruction, unless `stall_i` freezes them.
- Reset value of every output: 0.

## Structure
- Package `ex_pkg`:
  - state enum (IDLE, SHIFT);
  - `func` encodings per class;
  - branch condition codes;
  - `XLEN` and `RIDX` constants.
- Sub-module `ex_shifter`: contains the accumulator, the 5-bit count, the one-bit-per-step SLL/SRL/SRA/ROTL logic, and `busy`/`done` outputs. The top level holds the operand mux, the ALU and the output registers.

## Test plan
- Reset low for 2 cycles, then release: all outputs 0. ADD with A=5, `rs_value_i`=7, `immf_i`=0, `rd_i`=3 → next cycle `result_o`=12, `wb_o`=1, `wb_r_o`=3.
- SUB with A=1, immediate 2, `immf_i`=1 → `result_o`=0xFFFFFFFF. XOR 0xF0F0F0F0 with 0xFFFF0000 → 0x0F0FF0F0.
- SLL of A=1 by B=5: `stall_o` high for 5 cycles; after the 5th edge `result_o`=0x20 and `wb_o`=1. SRA of 0x80000000 by 4 → 0xF8000000. Shift by 0 → 1-cycle latency, `stall_o` never high.
- `stall_i` pulsed 2 cycles mid-shift → count frozen, total `stall_o` width = n+2. `rst` low mid-shift → outputs 0, IDLE.
- BR with `func`=01, A=0, B=0x100 → `br_taken_o` pulse, `br_target_o`=0x100. Same with A=1 → `br_taken_o`=0.
- ST with `rs_value_i`=0x10, immediate 4, A=0xAB → `mem_we_o`=1, `result_o`=0x14, `mem_wdata_o`=0xAB, `wb_o`=0. LD → `mem_re_o`=1, `wb_o`=1.
